uart_cmd_rcv: RTL and testbench

- Slave-side frame receiver; the downstream partner of the command-master transmitter.
- Consumes bytes from a UART receiver (rx_data/rx_rdy) and assembles a 3-byte frame (cmd, data_hi, data_lo) into cmd[7:0] + data[15:0], then flags cmd_rdy.
- Also owns the return path: transmits a single 8-bit response byte through the UART transmitter (trmt/tx_data/tx_done) on request.
- Sits between the UART core and the command-processing logic.

---
 rtl/uart_cmd_rcv.sv | 197 +++++++++++++++++++
 tb/tb_uart_cmd_rcv.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rcv.sv
// Slave-side frame receiver: assembles 3-byte command frames from the UART receiver
// and sends a single response byte through the UART transmitter. Optional macro: FRAME_TIMEOUT_EN.
module uart_cmd_rcv #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam logic [1:0] WAIT_CMD = 2'd0;
    localparam logic [1:0] WAIT_HI  = 2'd1;
    localparam logic [1:0] WAIT_LO  = 2'd2;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_BUSY = 1'b1;

    logic [1:0]  rx_state_r;
    logic [1:0]  rx_state_s;
    logic        cmd_rdy_r;
    logic        cmd_rdy_s;
    logic [7:0]  cmd_r;
    logic [7:0]  cmd_s;
    logic [15:0] data_r;
    logic [15:0] data_s;
    logic        timeout_s;

    logic [0:0]  tx_state_r;
    logic [0:0]  tx_state_s;
    logic        trmt_r;
    logic        trmt_s;
    logic [7:0]  tx_data_r;
    logic [7:0]  tx_data_s;
    logic        resp_sent_r;
    logic        resp_sent_s;

`ifdef FRAME_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt_r;
    logic [CNT_W-1:0] to_cnt_s;
    logic             frame_err_r;

    // A same-cycle rx_rdy always rescues the frame, even at terminal count.
    assign timeout_s = (rx_state_r != WAIT_CMD) && !rx_rdy &&
                       (to_cnt_r == CNT_W'(TIMEOUT_CYC));

    // Inter-byte counter: cleared by every byte, idle outside a partial frame.
    always_comb begin
        to_cnt_s = to_cnt_r;
        if ((rx_state_r == WAIT_CMD) || rx_rdy || timeout_s) begin
            to_cnt_s = {CNT_W{1'b0}};
        end else begin
            to_cnt_s = to_cnt_r + CNT_W'(1);
        end
    end

    // Timeout counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r    <= {CNT_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            to_cnt_r    <= to_cnt_s;
            frame_err_r <= timeout_s;
        end
    end

    assign frame_err = frame_err_r;
`else
    assign timeout_s = 1'b0;
    assign frame_err = 1'b0;
`endif

    // Receive next-state: clear request first, byte events override (set wins).
    always_comb begin
        rx_state_s = rx_state_r;
        cmd_s      = cmd_r;
        data_s     = data_r;
        cmd_rdy_s  = cmd_rdy_r & ~clr_cmd_rdy;
        if (timeout_s) begin
            rx_state_s = WAIT_CMD;
        end else begin
            case (rx_state_r)
                WAIT_CMD: begin
                    if (rx_rdy) begin
                        cmd_s      = rx_data;
                        cmd_rdy_s  = 1'b0;
                        rx_state_s = WAIT_HI;
                    end else begin
                        rx_state_s = WAIT_CMD;
                    end
                end
                WAIT_HI: begin
                    if (rx_rdy) begin
                        data_s[15:8] = rx_data;
                        rx_state_s   = WAIT_LO;
                    end else begin
                        rx_state_s = WAIT_HI;
                    end
                end
                WAIT_LO: begin
                    if (rx_rdy) begin
                        data_s[7:0] = rx_data;
                        cmd_rdy_s   = 1'b1;
                        rx_state_s  = WAIT_CMD;
                    end else begin
                        rx_state_s = WAIT_LO;
                    end
                end
                default: begin
                    rx_state_s = WAIT_CMD;
                end
            endcase
        end
    end

    // Receive state and frame holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= WAIT_CMD;
            cmd_rdy_r  <= 1'b0;
            cmd_r      <= 8'h00;
            data_r     <= 16'h0000;
        end else begin
            rx_state_r <= rx_state_s;
            cmd_rdy_r  <= cmd_rdy_s;
            cmd_r      <= cmd_s;
            data_r     <= data_s;
        end
    end

    // Transmit next-state: snd_resp while busy is dropped, tx_done while idle ignored.
    always_comb begin
        tx_state_s  = tx_state_r;
        tx_data_s   = tx_data_r;
        trmt_s      = 1'b0;
        resp_sent_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (snd_resp) begin
                    tx_data_s  = resp;
                    trmt_s     = 1'b1;
                    tx_state_s = TX_BUSY;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_s = 1'b1;
                    tx_state_s  = TX_IDLE;
                end else begin
                    tx_state_s = TX_BUSY;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
            end
        endcase
    end

    // Transmit state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r  <= TX_IDLE;
            trmt_r      <= 1'b0;
            tx_data_r   <= 8'h00;
            resp_sent_r <= 1'b0;
        end else begin
            tx_state_r  <= tx_state_s;
            trmt_r      <= trmt_s;
            tx_data_r   <= tx_data_s;
            resp_sent_r <= resp_sent_s;
        end
    end

    assign cmd_rdy   = cmd_rdy_r;
    assign cmd       = cmd_r;
    assign data      = data_r;
    assign trmt      = trmt_r;
    assign tx_data   = tx_data_r;
    assign resp_sent = resp_sent_r;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed plus randomized bench for uart_cmd_rcv against a byte-queue frame model.
`timescale 1ns/1ps
module tb_uart_cmd_rcv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  resp;
    logic        snd_resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  frame_q[$];
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic        m_rdy;
    logic        m_busy;
    logic [7:0]  m_tx;
    int          m_trmt_n;
    int          m_sent_n;
    int          m_ferr_n;

    int trmt_n = 0;
    int sent_n = 0;
    int ferr_n = 0;

    uart_cmd_rcv #(.TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .resp(resp), .snd_resp(snd_resp), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .resp_sent(resp_sent), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trmt === 1'b1) trmt_n++;
        if (resp_sent === 1'b1) sent_n++;
        if (frame_err === 1'b1) ferr_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_cmd = 8'h00; m_data = 16'h0000; m_rdy = 1'b0;
        m_busy = 1'b0; m_tx = 8'h00;
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_cmd"}, {8'h00, cmd}, {8'h00, m_cmd});
        check({tag, "_data"}, data, m_data);
        check({tag, "_rdy"}, {15'h0000, cmd_rdy}, {15'h0000, m_rdy});
    endtask

    task automatic model_byte(input logic [7:0] b, input logic clr);
        if (clr) m_rdy = 1'b0;
        frame_q.push_back(b);
        if (frame_q.size() == 1) begin
            m_cmd = b; m_rdy = 1'b0;
        end else if (frame_q.size() == 2) begin
            m_data[15:8] = b;
        end else begin
            m_data[7:0] = b; m_rdy = 1'b1;
            frame_q.delete();
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic clr);
        @(negedge clk);
        rx_data = b; rx_rdy = 1'b1; clr_cmd_rdy = clr;
        @(negedge clk);
        rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        model_byte(b, clr);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snd(input logic [7:0] r, input string tag);
        logic acc;
        acc = !m_busy;
        @(negedge clk);
        resp = r; snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        if (acc) begin
            m_tx = r; m_busy = 1'b1; m_trmt_n++;
        end
        check({tag, "_trmt"}, {15'h0000, trmt}, {15'h0000, acc});
        check({tag, "_txdata"}, {8'h00, tx_data}, {8'h00, m_tx});
    endtask

    task automatic done(input string tag);
        logic was_busy;
        was_busy = m_busy;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (was_busy) m_sent_n++;
        m_busy = 1'b0;
        check({tag, "_sent"}, {15'h0000, resp_sent}, {15'h0000, was_busy});
    endtask

    task automatic check_counts(input string tag);
        idle(2);
        check({tag, "_trmt_n"}, trmt_n[15:0], m_trmt_n[15:0]);
        check({tag, "_sent_n"}, sent_n[15:0], m_sent_n[15:0]);
        check({tag, "_ferr_n"}, ferr_n[15:0], m_ferr_n[15:0]);
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
        resp = 8'h00; snd_resp = 1'b0; tx_done = 1'b0;
        m_trmt_n = 0; m_sent_n = 0; m_ferr_n = 0;
        model_reset();
        idle(3);
        check_rx("reset");
        check("reset_trmt", {15'h0000, trmt}, 16'h0000);
        check("reset_txdata", {8'h00, tx_data}, 16'h0000);
        check("reset_sent", {15'h0000, resp_sent}, 16'h0000);
        check("reset_ferr", {15'h0000, frame_err}, 16'h0000);
        @(negedge clk) rst_n = 1'b1;

        // Basic frame with 10-cycle spacing
        rx_byte(8'h05, 1'b0); check_rx("f1_b1");
        idle(10);
        rx_byte(8'hAB, 1'b0); check_rx("f1_b2");
        idle(10);
        rx_byte(8'hCD, 1'b0); check_rx("f1_b3");
        check("f1_data_abs", data, 16'hABCD);

        // Clear, then set-wins frame
        clr_pulse(); check_rx("clr");
        check("clr_abs", {15'h0000, cmd_rdy}, 16'h0000);
        rx_byte(8'h06, 1'b0); rx_byte(8'h12, 1'b0); rx_byte(8'h34, 1'b1);
        check_rx("setwins");
        check("setwins_abs", data, 16'h1234);

        // New frame overwrites cmd and clears cmd_rdy
        rx_byte(8'h07, 1'b0); check_rx("ovr_b1");
        rx_byte(8'h44, 1'b0); rx_byte(8'h55, 1'b0); check_rx("ovr_done");

        // Clear together with a first byte
        rx_byte(8'h08, 1'b1); check_rx("clr_first");
        rx_byte(8'h66, 1'b0); rx_byte(8'h77, 1'b0); check_rx("clr_first_done");

        // Transmit path
        snd(8'hA5, "tx1");
        idle(1);
        check("tx1_trmt_once", {15'h0000, trmt}, 16'h0000);
        snd(8'h5A, "tx_busy");
        done("tx1_done");
        idle(1);
        check("tx1_sent_once", {15'h0000, resp_sent}, 16'h0000);
        done("tx_idle_done");
        snd(8'h3C, "tx2");
        done("tx2_done");
        check_counts("tx_dir");

        // Full duplex: byte and response request in the same cycle
        @(negedge clk);
        rx_data = 8'h0E; rx_rdy = 1'b1; resp = 8'hC3; snd_resp = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0; snd_resp = 1'b0;
        model_byte(8'h0E, 1'b0);
        m_tx = 8'hC3; m_busy = 1'b1; m_trmt_n++;
        check_rx("duplex_b1");
        check("duplex_txdata", {8'h00, tx_data}, {8'h00, m_tx});
        rx_byte(8'hBE, 1'b0); rx_byte(8'hEF, 1'b0); check_rx("duplex_done");
        done("duplex_txdone");

        // Reset mid-frame discards the partial frame
        rx_byte(8'h01, 1'b0); rx_byte(8'h02, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        model_reset();
        check_rx("midrst");
        check("midrst_txdata", {8'h00, tx_data}, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        rx_byte(8'h09, 1'b0); rx_byte(8'h00, 1'b0); rx_byte(8'h01, 1'b0);
        check_rx("midrst_after");
        check("midrst_abs", data, 16'h0001);
        check_counts("after_rst");

`ifdef FRAME_TIMEOUT_EN
        // Timeout: pulse exactly 21 cycles after the last byte edge
        clr_pulse();
        rx_byte(8'h05, 1'b0); rx_byte(8'hAB, 1'b0);
        idle(20);
        check("to_early", ferr_n[15:0], m_ferr_n[15:0]);
        idle(1);
        m_ferr_n++;
        frame_q.delete();
        check("to_fire", ferr_n[15:0], m_ferr_n[15:0]);
        idle(4);
        check("to_once", ferr_n[15:0], m_ferr_n[15:0]);
        check_rx("to_partial");
        rx_byte(8'h03, 1'b0); rx_byte(8'h00, 1'b0); rx_byte(8'h10, 1'b0);
        check_rx("to_recover");
        check("to_recover_abs", data, 16'h0010);
        // Third byte on the terminal-count cycle completes the frame
        rx_byte(8'h11, 1'b0); rx_byte(8'h22, 1'b0);
        idle(19);
        rx_byte(8'h33, 1'b0);
        check_rx("to_terminal");
        idle(30);
        check("to_terminal_noerr", ferr_n[15:0], m_ferr_n[15:0]);
`else
        // Partial frames wait indefinitely
        rx_byte(8'h0A, 1'b0); rx_byte(8'h0B, 1'b0);
        idle(100);
        rx_byte(8'h0C, 1'b0);
        check_rx("no_timeout");
`endif

        // Randomized frames with random gaps and clears
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 3; k++) begin
                rx_byte(8'($urandom), ($urandom_range(3, 0) == 0));
                if (k < 2) check_rx("rnd_partial");
                idle($urandom_range(10, 0));
            end
            check_rx("rnd_frame");
            if ($urandom_range(2, 0) == 0) begin
                clr_pulse();
                check_rx("rnd_clr");
            end
        end

        // Randomized transmit requests and completions
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1, 0) == 1) snd(8'($urandom), "rnd_snd");
            else done("rnd_done");
            idle($urandom_range(3, 0));
        end
        check_counts("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
